// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle controller and its ALU decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps ALUOp plus instruction function fields onto the ALU control code.
module aludec
    import mc_ctrl_pkg::*;
(
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] ALUOp,
    output logic [2:0] ALUControl
);

    // funct7b5 only selects sub for register-register ops; addi ignores it
    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM with memory-ready stalls.
// Optional performance counters are enabled by defining MC_CTRL_PERF_EN.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_ON_MEM = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_control,
    output logic       illegal_instr
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    state_t     r_state;
    state_t     w_nextState;
    logic       w_memReady;
    logic       w_pcUpdate;
    logic       w_branch;
    logic [1:0] w_aluOp;

    assign w_memReady = (WAIT_ON_MEM != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        w_pcUpdate    = 1'b0;
        w_branch      = 1'b0;
        w_aluOp       = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = w_memReady;
                w_pcUpdate = w_memReady;
                if (w_memReady) w_nextState = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: w_nextState = S_MEMADR;
                    OP_R:         w_nextState = S_EXECUTER;
                    OP_I:         w_nextState = S_EXECUTEI;
                    OP_BEQ:       w_nextState = S_BEQ;
                    OP_JAL:       w_nextState = S_JAL;
                    default: begin
                        w_nextState   = S_FETCH;
                        illegal_instr = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                w_nextState = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (w_memReady) w_nextState = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = RES_DATA;
                reg_write   = 1'b1;
                w_nextState = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (w_memReady) w_nextState = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a   = SRCA_RS1;
                w_aluOp     = ALUOP_FUNCT;
                w_nextState = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                w_aluOp     = ALUOP_FUNCT;
                w_nextState = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write   = 1'b1;
                w_nextState = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a   = SRCA_RS1;
                w_aluOp     = ALUOP_SUB;
                w_branch    = 1'b1;
                w_nextState = S_FETCH;
            end
            S_JAL: begin
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_FOUR;
                w_pcUpdate  = 1'b1;
                w_nextState = S_ALUWB;
            end
            default: w_nextState = S_FETCH;
        endcase
        // Reset must suppress every architectural write, even mid-instruction
        if (!reset_n) begin
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_write     = 1'b0;
            illegal_instr = 1'b0;
            w_pcUpdate    = 1'b0;
            w_branch      = 1'b0;
        end
        pc_write = w_pcUpdate | (w_branch & zero);
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

    aludec u_aludec (
        .opb5       (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ALUOp      (w_aluOp),
        .ALUControl (alu_control)
    );

`ifdef MC_CTRL_PERF_EN
    logic        w_retire;
    logic [31:0] r_cycleCnt;
    logic [31:0] r_instretCnt;

    // Retire on the last cycle of each legal instruction only
    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BEQ)
                   || ((r_state == S_MEMWRITE) && w_memReady);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cycleCnt   <= 32'd0;
            r_instretCnt <= 32'd0;
        end else begin
            r_cycleCnt <= r_cycleCnt + 32'd1;
            if (w_retire) r_instretCnt <= r_instretCnt + 32'd1;
        end
    end

    assign cycle_cnt   = r_cycleCnt;
    assign instret_cnt = r_instretCnt;
`endif

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control FSM for the RV32I subset datapath: lw, sw, R-type, I-type ALU, beq, jal.
- Sequences the shared ALU, instruction/data memory port, register file and PC, one instruction per several cycles.
- Generates datapath mux selects and enables from instruction fields, and drives ALUControl through the existing ALU decoder.
- Adds a memory-ready stall handshake on fetch, load and store.

Parameters:
- WAIT_ON_MEM, 1, when 1 the FETCH/MEMREAD/MEMWRITE states hold until mem_ready; when 0 mem_ready is ignored (treated as 1).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous reset, active-low
- op  in  7  instruction opcode bits [6:0]
- funct3  in  3  instruction bits [14:12]
- funct7b5  in  1  instruction bit 30
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0=PC, 1=Result
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction/OldPC register enable
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=ImmExt, 10=const 4
- imm_src  out  2  00=I, 01=S, 10=B, 11=J
- reg_write  out  1  register file write enable
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Interface: single clock clk; reset_n is synchronous and active-low.
- Reset: while reset_n=0, the state register loads FETCH on each clk edge. pc_write, ir_write, reg_write, mem_write and illegal_instr are forced to 0 combinationally while reset_n=0. After release, the first cycle is FETCH.
- Outputs are Moore (decoded from state), except:
  - pc_write = pc_update | (branch & zero)
  - imm_src is decoded from op
  - alu_control comes from the ALU decoder
- Any select not listed for a state is 00; any enable not listed is 0.
- States, outputs and transitions:
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write and pc_update are both gated by mem_ready. Go to DECODE when mem_ready, else hold.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other op -> FETCH, with illegal_instr=1 for this one cycle
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Go to MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
  - MEMREAD: adr_src=1, result_src=00. Go to MEMWB when mem_ready, else hold.
  - MEMWB: result_src=01, reg_write=1. Go to FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1. mem_write stays asserted for the whole stall. Go to FETCH when mem_ready.
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Go to ALUWB.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Go to ALUWB.
  - ALUWB: result_src=00, reg_write=1. Go to FETCH.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. Go to FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Go to ALUWB (writes PC+4 to rd).
- ALU decode rules:
  - alu_op=00 -> add; alu_op=01 -> sub.
  - alu_op=10 decodes funct3:
    - 000 -> sub if (op[5] & funct7b5), else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - any other funct3 -> 3'bxxx-free default add
- Latency: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles, each plus any mem_ready wait cycles.
- A reset_n=0 mid-instruction aborts it; no write enable is asserted after the reset edge.
- Unreachable state encodings go to FETCH.

Optional Feature:
- Macro: MC_CTRL_PERF_EN.
- With it defined, the block adds two ports:
  - cycle_cnt (out, 32): increments every cycle with reset_n=1.
  - instret_cnt (out, 32): increments on the final cycle of each instruction — MEMWB, ALUWB, BEQ, and MEMWRITE with mem_ready. Illegal opcodes do not count.
- Both counters reset to 0 and wrap from 0xFFFFFFFF to 0.
- Without it, the ports and logic are absent.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum
  - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - ALU_ADD/SUB/AND/OR/SLT codes
  - result_src, alu_src_a and alu_src_b encodings
- Sub-module: the existing aludec, instantiated with ports opb5=op[5], funct3, funct7b5, ALUOp.
- FSM and imm_src decode live in mc_controller.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with op=0000011 -> pc_write=0 and reg_write=0 during reset. The first cycle after release is FETCH with ir_write=mem_ready.
- lw with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 only in cycle 5, with result_src=01.
- sw with mem_ready low for 2 cycles in MEMWRITE -> mem_write=1 for 3 consecutive cycles, adr_src=1, then FETCH.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> alu_control=001 in EXECUTER and reg_write in ALUWB. The same inputs with op=0010011 give alu_control=000.
- beq with zero=1 -> pc_write=1 in the BEQ cycle; with zero=0 -> pc_write=0. jal -> pc_write=1 in JAL, then ALUWB with reg_write=1.
- op=1111111 -> illegal_instr=1 for exactly one cycle in DECODE, then FETCH. With MC_CTRL_PERF_EN, instret_cnt is unchanged while cycle_cnt advances by 3.
